// File: rtl/dfr_pkg.sv
// -----------------------------------------------------------------------------
// dfr_pkg
// Shared types and helpers for the delay-feedback reservoir (DFR) blocks.
//   seq_state_t  : sequencer state encoding (IDLE, DRIVE, SETTLE, CAPTURE).
//   node_idx_w() : index width for a node count; returns 1 when the count is 1
//                  so a single-node build still gets a legal 1-bit index.
// -----------------------------------------------------------------------------
package dfr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    SETTLE  = 2'd2,
    CAPTURE = 2'd3
  } seq_state_t;

  function automatic int node_idx_w(input int n);
    int w;
    if (n <= 1) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/reservoir_sequencer.sv
// -----------------------------------------------------------------------------
// reservoir_sequencer
// Walks one accepted input sample through every virtual node of the
// delay-feedback reservoir. Per node: apply the +/-1 mask to the sample, drive
// it on res_din with a one-cycle res_en pulse, wait the settle time, capture
// res_dout and offer it downstream as a state word (valid/ready).
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-low reset
//   s_valid/s_ready : sample handshake; s_ready is high only while idle
//   s_data          : sample (two's complement)
//   mask            : per-node sign, bit i = 1 -> +sample, 0 -> -sample
//   settle_cycles   : extra wait cycles between the enable pulse and capture
//   res_en/res_din  : reservoir enable pulse and masked sample
//   res_dout        : reservoir output tap
//   st_valid/st_ready, st_data, st_node, st_last : state word stream
//   busy            : sequencer is not idle
//   sample_done     : one-cycle pulse after the last node's word is accepted
// -----------------------------------------------------------------------------
module reservoir_sequencer
  import dfr_pkg::*;
#(
  parameter int VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_WIDTH  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [DATA_WIDTH-1:0]                 s_data,
  input  logic [VIRTUAL_NODES-1:0]              mask,
  input  logic [SETTLE_WIDTH-1:0]               settle_cycles,
  output logic                                  res_en,
  output logic [DATA_WIDTH-1:0]                 res_din,
  input  logic [DATA_WIDTH-1:0]                 res_dout,
  output logic                                  st_valid,
  input  logic                                  st_ready,
  output logic [DATA_WIDTH-1:0]                 st_data,
  output logic [node_idx_w(VIRTUAL_NODES)-1:0]  st_node,
  output logic                                  st_last,
  output logic                                  busy,
  output logic                                  sample_done
);

  localparam int NODE_W = node_idx_w(VIRTUAL_NODES);
  localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(VIRTUAL_NODES - 1);

  // Sign-apply one sample. Negation wraps, so the most negative value maps to
  // itself, which is what the reservoir expects.
  function automatic logic [DATA_WIDTH-1:0] apply_mask(
    input logic [DATA_WIDTH-1:0] sample,
    input logic                  positive
  );
    logic [DATA_WIDTH-1:0] r;
    if (positive) begin
      r = sample;
    end else begin
      r = ~sample + DATA_WIDTH'(1'b1);
    end
    return r;
  endfunction

  seq_state_t                state_r;
  logic [NODE_W-1:0]         node_r;
  logic [NODE_W-1:0]         next_node_s;
  logic [DATA_WIDTH-1:0]     sample_r;
  logic [VIRTUAL_NODES-1:0]  mask_r;
  logic [SETTLE_WIDTH-1:0]   settle_r;
  logic [SETTLE_WIDTH-1:0]   cnt_r;
  logic                      res_en_r;
  logic [DATA_WIDTH-1:0]     res_din_r;
  logic                      st_valid_r;
  logic [DATA_WIDTH-1:0]     st_data_r;
  logic [NODE_W-1:0]         st_node_r;
  logic                      st_last_r;
  logic                      busy_r;
  logic                      sample_done_r;

  // Only evaluated while the current node is not the last one, so it never
  // wraps past LAST_NODE in use.
  assign next_node_s = node_r + NODE_W'(1'b1);

  // Sequencer FSM with all handshake and reservoir outputs registered.
  // The res_din/res_en of the next node is registered on the transition into
  // DRIVE so that the pulse coincides with the DRIVE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      node_r        <= '0;
      sample_r      <= '0;
      mask_r        <= '0;
      settle_r      <= '0;
      cnt_r         <= '0;
      res_en_r      <= 1'b0;
      res_din_r     <= '0;
      st_valid_r    <= 1'b0;
      st_data_r     <= '0;
      st_node_r     <= '0;
      st_last_r     <= 1'b0;
      busy_r        <= 1'b0;
      sample_done_r <= 1'b0;
    end else begin
      res_en_r      <= 1'b0;
      sample_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (s_valid) begin
            sample_r  <= s_data;
            mask_r    <= mask;
            settle_r  <= settle_cycles;
            node_r    <= '0;
            res_din_r <= apply_mask(s_data, mask[0]);
            res_en_r  <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= DRIVE;
          end
        end
        DRIVE: begin
          cnt_r   <= settle_r;
          state_r <= SETTLE;
        end
        SETTLE: begin
          if (cnt_r == {SETTLE_WIDTH{1'b0}}) begin
            st_valid_r <= 1'b1;
            st_data_r  <= res_dout;
            st_node_r  <= node_r;
            st_last_r  <= (node_r == LAST_NODE);
            state_r    <= CAPTURE;
          end else begin
            cnt_r <= cnt_r - SETTLE_WIDTH'(1'b1);
          end
        end
        CAPTURE: begin
          // The word stays untouched until it is accepted.
          if (st_ready) begin
            st_valid_r <= 1'b0;
            if (st_last_r) begin
              sample_done_r <= 1'b1;
              busy_r        <= 1'b0;
              state_r       <= IDLE;
            end else begin
              node_r    <= next_node_s;
              res_din_r <= apply_mask(sample_r, mask_r[next_node_s]);
              res_en_r  <= 1'b1;
              state_r   <= DRIVE;
            end
          end
        end
        default: begin
          st_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign s_ready     = (state_r == IDLE);
  assign res_en      = res_en_r;
  assign res_din     = res_din_r;
  assign st_valid    = st_valid_r;
  assign st_data     = st_data_r;
  assign st_node     = st_node_r;
  assign st_last     = st_last_r;
  assign busy        = busy_r;
  assign sample_done = sample_done_r;

endmodule
